// File: rtl/mem_fill_responder.sv
// Backing main memory for the cache miss protocol.
//
// Accepts a line-fill request, then streams the eight 16-bit words of the aligned 16-byte line
// as eight back-to-back beats, beat 0 appearing LATENCY cycles after the request is accepted.
// Single-word write-through stores are absorbed every cycle in any state.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_addr  line-fill request (byte address, low nibble ignored)
//   req_ready           request accepted when req_valid & req_ready at a rising edge
//   wr_en/wr_addr/wr_data  one-word write (byte address, bit 0 ignored)
//   rsp_valid/rsp_data  returned beat; rsp_data is zero when rsp_valid is low
//   rsp_beat/rsp_last   beat index within the line; rsp_last marks the final beat
//   busy                fill in progress
module mem_fill_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned BEATS      = 8,
  parameter int unsigned DEPTH_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_beat,
  output logic        rsp_last,
  output logic        busy
);

  localparam int unsigned PipeDepth = LATENCY - 1;
  localparam int unsigned Words     = 1 << DEPTH_LOG2;
  localparam logic [2:0]  LastBeat  = 3'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e      state_q, state_d;
  logic [11:0] line_q, line_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        issue_valid;
  logic        issue_last;

  logic [15:0]           mem [Words];
  logic [15:0]           rd_byte_addr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [15:0]           rd_data;

  logic        pipe_valid_q [PipeDepth];
  logic [15:0] pipe_data_q  [PipeDepth];
  logic [2:0]  pipe_beat_q  [PipeDepth];
  logic        pipe_last_q  [PipeDepth];

  logic        out_valid;
  logic        out_last;
  logic        unused_addr_bits;

  // Beat address is base + 2k with k <= 7, so it never carries out of the line.
  assign rd_byte_addr = {line_q, cnt_q, 1'b0};
  assign rd_idx       = rd_byte_addr[DEPTH_LOG2:1];
  assign wr_idx       = wr_addr[DEPTH_LOG2:1];

  // Write-first: a same-cycle write to the word being issued is what the beat returns.
  assign rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

  assign unused_addr_bits = ^{req_addr[3:0], wr_addr[0], rd_byte_addr[0]};

  assign out_valid = pipe_valid_q[PipeDepth-1];
  assign out_last  = pipe_last_q[PipeDepth-1];

  // Storage is deliberately not reset; a write coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    issue_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          line_d  = req_addr[15:4];
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        issue_valid = 1'b1;
        cnt_d       = cnt_q + 3'd1;
        if (cnt_q == LastBeat) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_valid && out_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign issue_last = issue_valid && (cnt_q == LastBeat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  // Delay pipe; invalid slots carry zeros so the outputs need no extra gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < PipeDepth; s++) begin
        pipe_valid_q[s] <= 1'b0;
        pipe_data_q[s]  <= '0;
        pipe_beat_q[s]  <= '0;
        pipe_last_q[s]  <= 1'b0;
      end
    end else begin
      pipe_valid_q[0] <= issue_valid;
      pipe_data_q[0]  <= issue_valid ? rd_data : 16'h0;
      pipe_beat_q[0]  <= issue_valid ? cnt_q : 3'd0;
      pipe_last_q[0]  <= issue_last;
      for (int unsigned s = 1; s < PipeDepth; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
        pipe_data_q[s]  <= pipe_data_q[s-1];
        pipe_beat_q[s]  <= pipe_beat_q[s-1];
        pipe_last_q[s]  <= pipe_last_q[s-1];
      end
    end
  end

  assign rsp_valid = out_valid;
  assign rsp_data  = pipe_data_q[PipeDepth-1];
  assign rsp_beat  = pipe_beat_q[PipeDepth-1];
  assign rsp_last  = out_last;

  assign req_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_fill_responder.sv
module tb_mem_fill_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  logic        req_ready,  rsp_valid,  rsp_last,  busy;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_beat;
  logic        req_ready2, rsp_valid2, rsp_last2, busy2;
  logic [15:0] rsp_data2;
  logic [2:0]  rsp_beat2;

  mem_fill_responder #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_beat(rsp_beat), .rsp_last(rsp_last), .busy(busy)
  );

  mem_fill_responder #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsp_valid(rsp_valid2),
    .rsp_data(rsp_data2), .rsp_beat(rsp_beat2), .rsp_last(rsp_last2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed tuple: {valid, beat[2:0], last, data[15:0], busy, ready}
  logic [22:0] obs1, obs2;
  assign obs1 = {rsp_valid, rsp_beat, rsp_last, rsp_data, busy, req_ready};
  assign obs2 = {rsp_valid2, rsp_beat2, rsp_last2, rsp_data2, busy2, req_ready2};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory (word addressed) and the words each beat of the current fill must carry.
  logic [15:0] ref_mem [32768];
  logic [15:0] ex [8];

  // Expected tuple i cycles after a fill is accepted, from the published timing rules.
  function automatic logic [22:0] expect_at(int i, int lat);
    int          k;
    logic        v;
    logic [2:0]  bt;
    logic [15:0] d;
    logic        bsy, rdy;
    k   = i - lat;
    v   = (k >= 0) && (k < 8);
    bt  = 3'd0;
    d   = 16'h0;
    if (v) begin
      bt = 3'(k);
      d  = ex[k];
    end
    bsy = (i >= 1) && (i <= lat + 7);
    rdy = (i == 0) || (i >= lat + 8);
    return {v, bt, v && (k == 7), d, bsy, rdy};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_write(input logic en, input logic [15:0] a, input logic [15:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
    if (en && !rst) ref_mem[a[15:1]] = d;
  endtask

  task automatic preload_line(input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      set_write(1'b1, {base[15:4], 4'h0} + 16'(2 * k), 16'($urandom));
      tick();
    end
    set_write(1'b0, 16'h0, 16'h0);
  endtask

  // Record what beat k of a fill of 'line' must return, after this cycle's write is applied.
  task automatic capture(input logic [15:0] line, input int i);
    if (i >= 1 && i <= 8) ex[i-1] = ref_mem[{line[15:4], 3'(i - 1)}];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs1 !== 23'h0 || obs2 !== 23'h0) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: got %h/%h want 0/0", i, obs1, obs2);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs1 !== 23'h1 || obs2 !== 23'h1) begin
      n_fail++;
      $display("FAIL reset_release: got %h/%h want 000001/000001", obs1, obs2);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 8; k++) begin
      set_write(1'b1, 16'h1000 + 16'(2 * k), 16'h00A0 + 16'(k));
      tick();
    end
    set_write(1'b0, 16'h0, 16'h0);
    for (int i = 0; i <= 13; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs1 !== expect_at(i, 4)) begin
        n_fail++;
        $display("FAIL basic_lat4 c%0d: got %h want %h", i, obs1, expect_at(i, 4));
      end
      n_checks++;
      if (obs2 !== expect_at(i, 2)) begin
        n_fail++;
        $display("FAIL basic_lat2 c%0d: got %h want %h", i, obs2, expect_at(i, 2));
      end
      req_valid = (i == 0);
      req_addr  = 16'h1006;
      capture(16'h1006, i);
    end
  endtask

  task automatic test_busy();
    int nbeats = 0;
    logic [22:0] e;
    preload_line(16'h2000);
    for (int i = 0; i <= 27; i++) begin
      if (i > 0) tick();
      e = (i < 12) ? expect_at(i, 4) : expect_at(i - 12, 4);
      if (rsp_valid === 1'b1) nbeats++;
      n_checks++;
      if (obs1 !== e) begin
        n_fail++;
        $display("FAIL busy_hold c%0d: got %h want %h", i, obs1, e);
      end
      req_valid = (i <= 12);
      req_addr  = 16'h2000;
      if (i < 12) capture(16'h2000, i);
      else capture(16'h2000, i - 12);
    end
    n_checks++;
    if (nbeats != 16) begin
      n_fail++;
      $display("FAIL busy_beat_count: got %0d want 16", nbeats);
    end
  endtask

  task automatic test_collision();
    int          wc [3] = '{3, 4, -1};
    logic [15:0] want [3] = '{16'hBEEF, 16'h1234, 16'hBEEF};
    logic [15:0] b2;
    preload_line(16'h3000);
    for (int f = 0; f < 3; f++) begin
      if (f < 2) begin
        set_write(1'b1, 16'h3004, 16'h1234);
        tick();
        set_write(1'b0, 16'h0, 16'h0);
      end
      b2 = 16'hxxxx;
      for (int i = 0; i <= 13; i++) begin
        if (i > 0) tick();
        if (rsp_valid === 1'b1 && rsp_beat === 3'd2) b2 = rsp_data;
        n_checks++;
        if (obs1 !== expect_at(i, 4)) begin
          n_fail++;
          $display("FAIL collide%0d c%0d: got %h want %h", f, i, obs1, expect_at(i, 4));
        end
        req_valid = (i == 0);
        req_addr  = 16'h3000;
        if (i == wc[f]) set_write(1'b1, 16'h3004, 16'hBEEF);
        else set_write(1'b0, 16'h0, 16'h0);
        capture(16'h3000, i);
      end
      n_checks++;
      if (b2 !== want[f]) begin
        n_fail++;
        $display("FAIL collide%0d_beat2: got %h want %h", f, b2, want[f]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] e;
    preload_line(16'h4000);
    set_write(1'b1, 16'h4000, 16'h0BAD);
    tick();
    set_write(1'b0, 16'h0, 16'h0);
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) tick();
      if (i <= 6) e = expect_at(i, 4);
      else if (i == 7) e = 23'h0;
      else e = 23'h1;
      n_checks++;
      if (obs1 !== e) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %h want %h", i, obs1, e);
      end
      req_valid = (i == 0);
      req_addr  = 16'h4000;
      rst       = (i == 6);
      // This write coincides with rst and must be dropped.
      if (i == 6) set_write(1'b1, 16'h4000, 16'hDEAD);
      else set_write(1'b0, 16'h0, 16'h0);
      capture(16'h4000, i);
    end
    for (int i = 0; i <= 13; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (obs1 !== expect_at(i, 4)) begin
        n_fail++;
        $display("FAIL reset_refill c%0d: got %h want %h", i, obs1, expect_at(i, 4));
      end
      if (i == 4) begin
        n_checks++;
        if (rsp_data !== 16'h0BAD) begin
          n_fail++;
          $display("FAIL reset_wr_discard: got %h want 0bad", rsp_data);
        end
      end
      req_valid = (i == 0);
      req_addr  = 16'h4000;
      capture(16'h4000, i);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] lines [2] = '{16'hFFF1, 16'h0000};
    preload_line(16'hFFF0);
    set_write(1'b1, 16'hFFFE, 16'h5555);
    tick();
    preload_line(16'h0000);
    set_write(1'b1, 16'h0000, 16'h1111);
    tick();
    set_write(1'b1, 16'h0001, 16'h7777);
    tick();
    set_write(1'b0, 16'h0, 16'h0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i <= 13; i++) begin
        if (i > 0) tick();
        n_checks++;
        if (obs1 !== expect_at(i, 4)) begin
          n_fail++;
          $display("FAIL wrap%0d c%0d: got %h want %h", f, i, obs1, expect_at(i, 4));
        end
        if (f == 0 && i == 11) begin
          n_checks++;
          if (rsp_data !== 16'h5555 || rsp_last !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_top_beat7: got %h last %b want 5555 last 1", rsp_data, rsp_last);
          end
        end
        if (f == 1 && i == 4) begin
          n_checks++;
          if (rsp_data !== 16'h7777) begin
            n_fail++;
            $display("FAIL wrap_bit0_alias: got %h want 7777", rsp_data);
          end
        end
        req_valid = (i == 0);
        req_addr  = lines[f];
        capture(lines[f], i);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] line;
    int          len;
    for (int f = 0; f < 20; f++) begin
      line = 16'($urandom);
      preload_line(line);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      len = 12 + int'($urandom_range(0, 3));
      for (int i = 0; i <= len; i++) begin
        if (i > 0) tick();
        n_checks++;
        if (obs1 !== expect_at(i, 4)) begin
          n_fail++;
          $display("FAIL random%0d c%0d: got %h want %h", f, i, obs1, expect_at(i, 4));
        end
        req_valid = (i == 0);
        req_addr  = line;
        if ($urandom_range(0, 1) == 1)
          set_write(1'b1, {line[15:4], 4'($urandom)}, 16'($urandom));
        else set_write(1'b0, 16'h0, 16'h0);
        capture(line, i);
      end
      set_write(1'b0, 16'h0, 16'h0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0;
    wr_en     = 1'b0;
    wr_addr   = 16'h0;
    wr_data   = 16'h0;
    test_reset();
    test_basic();
    test_busy();
    test_collision();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_fill_responder.md
# mem_fill_responder

Memory-side responder for the cache subsystem's miss protocol. It accepts a 16-byte line-fill request from the cache miss FSM, then returns the eight 16-bit words of that line as eight consecutive beats after a fixed pipelined latency. It also absorbs single-word write-through stores from the data cache. It is the backing main memory that the I-cache and D-cache fill logic talks to.

## Interface
Parameters:
- LATENCY, 4, cycles from request acceptance to beat 0 on the response port; legal range 2..8
- BEATS, 8, words per line; fixed at 8 (16-byte line)
- DEPTH_LOG2, 15, log2 of the word count of the storage array

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  line-fill request present
- req_addr  in  16  byte address; line base = {req_addr[15:4], 4'b0}
- req_ready  out  1  responder can accept a request this cycle
- wr_en  in  1  write one word this cycle
- wr_addr  in  16  byte address of the write; bit 0 ignored
- wr_data  in  16  write data
- rsp_valid  out  1  rsp_data holds a valid beat
- rsp_data  out  16  returned word
- rsp_beat  out  3  beat index k (word at line base + 2k)
- rsp_last  out  1  high with the final beat (k = BEATS-1)
- busy  out  1  fill in progress

## Operation
- Word index into the array = addr[DEPTH_LOG2:1]; bits above are ignored, so the space wraps.
- State machine:
  - IDLE
    - req_ready = 1, busy = 0.
    - req_valid & req_ready at an edge accepts the request: latch line base, clear issue counter, go to ISSUE.
  - ISSUE
    - One array read per cycle for k = 0..BEATS-1, in order.
    - Each read enters a (LATENCY-1)-stage delay pipe that carries the data, k, and the last flag.
    - After issuing k = BEATS-1, go to DRAIN.
  - DRAIN
    - Wait until the beat with the last flag leaves the pipe, then return to IDLE.
- busy = 1 and req_ready = 0 in ISSUE and DRAIN. Requests presented then are ignored, not queued; the requester holds req_valid.
- Beat addresses never carry past the line: base + 2k with k ≤ 7 stays within the aligned 16 bytes.
- Writes:
  - Accepted every cycle in any state; no ready signal.
  - The array is updated at the edge where wr_en is sampled high.
  - If a write and a beat read hit the same word in the same cycle, the beat returns wr_data (write-first).
  - Writes that commit after a beat's issue cycle are not reflected in that beat.
- Array contents are unaffected by rst.

## Timing
- Request accepted at edge of cycle T0.
- Beat k issued in cycle T0+1+k.
- rsp_valid high in cycles T0+LATENCY+k, k = 0..7: eight consecutive cycles with no bubbles.
- rsp_last high only in cycle T0+LATENCY+7.
- busy high in cycles T0+1 through T0+LATENCY+7 inclusive.
- req_ready returns high in cycle T0+LATENCY+8. Minimum request-to-request spacing is LATENCY+8 cycles (12 by default).
- rsp_data, rsp_beat and rsp_last are 0 whenever rsp_valid = 0.
- Reset values (in the cycle after rst is sampled high, and while it is held):
  - rsp_valid = 0, rsp_data = 0, rsp_beat = 0, rsp_last = 0, busy = 0.
  - req_ready = 0 while rst is high; 1 from the first cycle after rst deasserts.
- Reset mid-fill:
  - Flushes the delay pipe and returns the FSM to IDLE.
  - No beat of the aborted fill appears afterwards.
  - A write sampled in the same cycle as rst = 1 is discarded.

## Test plan
- Basic fill:
  - Preload words 0x1000..0x100E with 0xA0..0xA7, then req_addr = 0x1006 at T0.
  - Beats 0xA0..0xA7, rsp_beat 0..7, in cycles T0+4..T0+11; rsp_last only at T0+11; req_ready high at T0+12.
- Busy rejection:
  - Hold req_valid with addr 0x2000 continuously from T0.
  - Second fill is accepted only at T0+12; its first beat appears at T0+16; exactly 16 beats total.
- Write/read collision:
  - During a fill of 0x3000 accepted at T0, write 0xBEEF to 0x3004 in cycle T0+3 (beat 2 issue cycle).
  - Beat 2 = 0xBEEF.
  - The same write in T0+4 instead: beat 2 returns the old value, and a later fill returns 0xBEEF.
- Reset mid-fill:
  - Assert rst in cycle T0+6.
  - rsp_valid = 0 from T0+7 onward, with no stray beats.
  - A new fill accepted after rst deasserts returns correct data with latency 4.
- Address wrap and top line:
  - Write 0x5555 to 0xFFFE.
  - Fill req_addr = 0xFFF1 returns beat 7 = 0x5555 with rsp_last.
  - A write to 0x0001 updates the same word as 0x0000.
- LATENCY = 2 build: basic fill gives beat 0 at T0+2 and req_ready high again at T0+10.
